// File: rtl/fp_addsub_issue.sv
// ============================================================================
// Module   : fp_addsub_issue
// Brief    : Operand FIFO, hold/settle sequencer and result capture for the
//            FP add/sub unit. Optional macro ISSUE_EXC_COUNT_EN adds a
//            saturating count of delivered exception results (o_exc_count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_addsub_issue #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_operand_a,
    input  logic [WIDTH-1:0]         i_operand_b,
    input  logic                     i_add_sub,
    output logic [WIDTH-1:0]         o_operand_a,
    output logic [WIDTH-1:0]         o_operand_b,
    output logic                     o_add_sub_signal,
    input  logic [WIDTH-1:0]         i_result,
    input  logic                     i_exception,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_result,
    output logic                     o_exception,
`ifdef ISSUE_EXC_COUNT_EN
    output logic [15:0]              o_exc_count,
`endif
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * WIDTH + 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
    localparam logic [LW-1:0] C_LAT_M1 = LW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [EW-1:0]   head;
    logic [LW-1:0]   settle_cnt;
    logic            push;
    logic            pop;
    logic            capture;
    logic            release_out;

    assign o_ready = (o_count != C_FULL);
    assign push    = i_valid && o_ready;
    assign head    = mem[rd_ptr];

    // FIFO storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_operand_a, i_operand_b, i_add_sub};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (o_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (settle_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    release_out = 1'b1;
                    // Back-to-back issue straight out of the handshake edge.
                    if (o_count != '0) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_operand_a      <= '0;
            o_operand_b      <= '0;
            o_add_sub_signal <= 1'b0;
            settle_cnt       <= '0;
            o_result         <= '0;
            o_exception      <= 1'b0;
            o_valid          <= 1'b0;
        end else begin
            if (pop) begin
                {o_operand_a, o_operand_b, o_add_sub_signal} <= head;
                settle_cnt <= C_LAT_M1;
            end else if ((state == ISSUE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - LW'(1);
            end
            if (capture) begin
                o_result    <= i_result;
                o_exception <= i_exception;
                o_valid     <= 1'b1;
            end else if (release_out) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef ISSUE_EXC_COUNT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_exc_count <= '0;
        end else if (o_valid && i_ready && o_exception && (o_exc_count != 16'hFFFF)) begin
            o_exc_count <= o_exc_count + 16'd1;
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_issue.sv
// ============================================================================
// Module   : tb_fp_addsub_issue
// Brief    : Directed self-checking bench for fp_addsub_issue with a delayed
//            table-driven adder model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_addsub_issue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LATENCY = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready_o;
    logic [WIDTH-1:0]  a_in = '0;
    logic [WIDTH-1:0]  b_in = '0;
    logic              op_in = 1'b0;
    logic [WIDTH-1:0]  hold_a;
    logic [WIDTH-1:0]  hold_b;
    logic              hold_op;
    logic [WIDTH-1:0]  add_result;
    logic              add_exc;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_result;
    logic              out_exc;
    logic [2:0]        count;
`ifdef ISSUE_EXC_COUNT_EN
    logic [15:0]       exc_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_addsub_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_valid          (in_valid),
        .o_ready          (in_ready_o),
        .i_operand_a      (a_in),
        .i_operand_b      (b_in),
        .i_add_sub        (op_in),
        .o_operand_a      (hold_a),
        .o_operand_b      (hold_b),
        .o_add_sub_signal (hold_op),
        .i_result         (add_result),
        .i_exception      (add_exc),
        .o_valid          (out_valid),
        .i_ready          (out_ready),
        .o_result         (out_result),
        .o_exception      (out_exc),
`ifdef ISSUE_EXC_COUNT_EN
        .o_exc_count      (exc_count),
`endif
        .o_count          (count)
    );

    // Adder model: table lookup, visible only after LATENCY-1 clocks.
    function automatic logic [32:0] adder_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3F800000 && b == 32'h40000000)
            return op ? {1'b0, 32'hBF800000} : {1'b0, 32'h40400000};
        else if (a == 32'h7F800000 && b == 32'hFF800000 && !op)
            return {1'b1, 32'h7FC00000};
        else
            return {1'b0, a ^ b};
    endfunction

    logic [32:0] p0 = '0;
    logic [32:0] p1 = '0;
    logic [32:0] p2 = '0;
    always @(posedge clk) begin
        p0 <= adder_fn(hold_a, hold_b, hold_op);
        p1 <= p0;
        p2 <= p1;
    end
    assign add_result = p2[31:0];
    assign add_exc    = p2[32];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic op);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        op_in = op;
        step();
        in_valid = 1'b0;
    endtask

    task automatic deliver(input string tag, input logic [31:0] er, input logic ee, input int stall);
        int n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " result"}, out_result, er);
        chk({tag, " exc"}, out_exc, ee);
        for (int k = 0; k < stall; k++) begin
            step();
            chk({tag, " stall valid"}, out_valid, 1);
            chk({tag, " stall result"}, out_result, er);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " valid drop"}, out_valid, 0);
    endtask

    initial begin
        int accepted;
        logic seen;

        // 1: reset / idle
        repeat (10) begin
            step();
        end
        chk("rst ready", in_ready_o, 1);
        chk("rst count", count, 0);
        chk("rst valid", out_valid, 0);
        rst_n = 1'b1;
        repeat (3) begin
            step();
        end
        chk("idle hold_a", hold_a, 0);
        chk("idle result", out_result, 0);
        chk("idle valid", out_valid, 0);
        chk("idle count", count, 0);

        // 2: single add with exact timing
        push(32'h3F800000, 32'h40000000, 1'b0);
        chk("t2 count P", count, 1);
        step();
        chk("t2 hold_a", hold_a, 32'h3F800000);
        chk("t2 hold_b", hold_b, 32'h40000000);
        chk("t2 hold_op", hold_op, 0);
        chk("t2 count P1", count, 0);
        for (int k = 0; k < LATENCY - 1; k++) begin
            step();
            chk("t2 early valid", out_valid, 0);
        end
        step();
        chk("t2 valid", out_valid, 1);
        chk("t2 result", out_result, 32'h40400000);
        chk("t2 exc", out_exc, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2 valid drop", out_valid, 0);

        // 3: back-to-back with stall
        push(32'h3F800000, 32'h40000000, 1'b0);
        push(32'h3F800000, 32'h40000000, 1'b1);
        push(32'h7F800000, 32'hFF800000, 1'b0);
        deliver("t3 r0", 32'h40400000, 1'b0, 6);
        deliver("t3 r1", 32'hBF800000, 1'b0, 0);
        deliver("t3 r2", 32'h7FC00000, 1'b1, 0);

        // 4: full FIFO
        accepted = 0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            a_in = i;
            b_in = 32'h0;
            op_in = 1'b0;
            if (in_ready_o) accepted++;
            step();
        end
        in_valid = 1'b0;
        chk("t4 accepted", accepted, DEPTH + 1);
        chk("t4 ready", in_ready_o, 0);
        chk("t4 count", count, DEPTH);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            deliver("t4 drain", i, 1'b0, 0);
        end
        chk("t4 empty", count, 0);

        // 5: reset mid-ISSUE
        push(32'h11111111, 32'h0, 1'b0);
        push(32'h22222222, 32'h0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t5 valid", out_valid, 0);
        chk("t5 count", count, 0);
        chk("t5 ready", in_ready_o, 1);
        chk("t5 hold_a", hold_a, 0);
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            step();
            seen |= out_valid;
        end
        chk("t5 no result", seen, 0);

        // 6: exception results
        push(32'h7F800000, 32'hFF800000, 1'b0);
        push(32'h3F800000, 32'h40000000, 1'b0);
        push(32'h7F800000, 32'hFF800000, 1'b0);
        deliver("t6 r0", 32'h7FC00000, 1'b1, 0);
        deliver("t6 r1", 32'h40400000, 1'b0, 0);
        deliver("t6 r2", 32'h7FC00000, 1'b1, 0);
`ifdef ISSUE_EXC_COUNT_EN
        chk("t6 exc_count", exc_count, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_addsub_issue.md
Name: fp_addsub_issue

Overview:
Operand issue and result-capture stage that sits directly upstream of the floating-point add/subtract unit.
- Buffers incoming single-precision operand pairs and their add/sub select in a small FIFO.
- Presents one pair at a time to the adder, holds it stable for the adder's fixed settle latency, then captures the adder's result and exception flag.
- Offers the captured result downstream with a valid/ready handshake, so the adder can be driven at full rate by producers that stall.

Parameters:
WIDTH, 32, operand/result width in bits (IEEE-754 single).
DEPTH, 4, FIFO entries; power of two, >= 2.
LATENCY, 4, cycles operands must be held before the adder output is sampled; >= 1.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous active-low reset.
i_valid  in  1  upstream operand pair valid.
o_ready  out  1  FIFO can accept (= not full).
i_operand_a  in  WIDTH  operand A.
i_operand_b  in  WIDTH  operand B.
i_add_sub  in  1  0 = add, 1 = subtract.
o_operand_a  out  WIDTH  held operand A to adder.
o_operand_b  out  WIDTH  held operand B to adder.
o_add_sub_signal  out  1  held op select to adder.
i_result  in  WIDTH  adder result (o_operand_o of adder).
i_exception  in  1  adder exception flag.
o_valid  out  1  captured result valid.
i_ready  in  1  downstream accepts result.
o_result  out  WIDTH  captured result.
o_exception  out  1  captured exception.
o_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - FIFO emptied; o_count=0.
  - State IDLE.
  - o_operand_a, o_operand_b, o_add_sub_signal, o_result, o_exception, o_valid all 0.
  - o_ready=1 while in reset, since it is combinational from "not full".
- FIFO:
  - Entry = {a, b, op}, 2*WIDTH+1 bits.
  - Push when i_valid && o_ready.
  - o_ready = (o_count != DEPTH). There is no push when full, even if a pop occurs in the same cycle.
  - Read/write pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves o_count unchanged.
- State machine:
  - IDLE: if o_count != 0, pop the head into the o_operand_*/o_add_sub_signal hold registers, load counter=LATENCY-1, go to ISSUE. Otherwise stay.
  - ISSUE: hold registers are constant. If counter != 0, decrement. If counter == 0, latch i_result->o_result and i_exception->o_exception, set o_valid=1, go to DONE.
  - DONE: o_valid, o_result and o_exception are held until i_ready=1.
    - On the handshake edge with FIFO non-empty: clear o_valid, pop the next entry into the hold registers, counter=LATENCY-1, go to ISSUE (back-to-back).
    - On the handshake edge with FIFO empty: clear o_valid, go to IDLE.
- Timing:
  - Entry pushed at edge P into an empty FIFO with IDLE state: popped at P+1; o_valid rises at edge P+1+LATENCY.
  - Hold registers are stable for exactly LATENCY cycles before the capture edge.
  - Steady-state throughput with i_ready=1: one result per LATENCY+1 cycles.
- Hold registers keep their last values in IDLE and DONE; they are not cleared.
- Reset asserted mid-operation aborts the operation: queued and in-flight pairs are discarded, no result is emitted.
- No arithmetic is performed in this block; all data is passed bit-exact.

Optional Feature:
Macro ISSUE_EXC_COUNT_EN.
- Defined: adds output port o_exc_count [15:0], reset to 0. It increments on every output handshake (o_valid && i_ready) where o_exception=1, and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset/idle: hold i_rst=0 for 10 cycles, then release -> all outputs 0, o_ready=1, o_count=0, o_valid stays 0 with no input.
2. Single add: push a=3F800000, b=40000000, op=0 at edge P.
   - Bench adder model returns 40400000, settling within LATENCY.
   - Expect o_operand_a=3F800000 from P+1; o_valid=1, o_result=40400000 at edge P+5 (LATENCY=4); o_exception=0.
3. Back-to-back with stall: push three pairs (the case-2 pair, the same pair with op=1 -> BF800000, and 7F800000+FF800000 -> exception=1). Hold i_ready=0 for 6 cycles after the first o_valid.
   - Expect results in order, each held unchanged during the stall, with no loss.
   - Third result has o_exception=1.
4. Full FIFO: i_ready=0, push continuously -> o_ready falls after the FIFO reaches o_count=DEPTH; extra i_valid beats are ignored; total accepted = DEPTH+1 (one entry is in the hold registers).
5. Reset mid-ISSUE: pull i_rst low two cycles after a pop -> o_valid=0 and o_count=0 immediately (asynchronous); no result ever appears after release.
6. With ISSUE_EXC_COUNT_EN: deliver 3 results, 2 of them with exception -> o_exc_count=2.
